// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage data memory access controller.
// Turns a load/store request from the pipeline into a word-aligned bus
// transaction (byte enables, lane-replicated store data), waits for the
// single-cycle bus acknowledge, and returns the selected and extended load data.
// A watchdog aborts an access that receives no ack within TO_CYCLES.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   memen_i         M-stage instruction is a load/store
//   memwrite_i      1 = store, 0 = load
//   memsize_i       00 byte, 01 half, 10/11 word
//   memsign_i       sign-extend loads when 1
//   addr_i          byte address
//   wdata_i         store data
//   stall_o         pipeline freeze while an access is outstanding
//   rdata_o         registered, extended load data
//   bus_err_o       one-cycle pulse after a bus timeout
//   dreq_o .. dwdata_o  bus request, write enable, byte enables, word address, data
//   dack_i, drdata_i    bus acknowledge and read data
//
// Optional build macro MEM_ADDR_EXC_EN: misaligned accesses skip the bus and
// raise adel_o/ades_o, recording the faulting address in badvaddr_o.
module mem_access_unit #(
   parameter int unsigned TO_CYCLES   = 255,
   parameter logic [31:0] RESET_RDATA = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memen_i,
   input  logic        memwrite_i,
   input  logic [1:0]  memsize_i,
   input  logic        memsign_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        bus_err_o,
   output logic        dreq_o,
   output logic        dwe_o,
   output logic [3:0]  dbe_o,
   output logic [31:0] daddr_o,
   output logic [31:0] dwdata_o,
`ifdef MEM_ADDR_EXC_EN
   output logic        adel_o,
   output logic        ades_o,
   output logic [31:0] badvaddr_o,
`endif
   input  logic        dack_i,
   input  logic [31:0] drdata_i
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

   localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

   stateT       state;
   logic [7:0]  toCnt;
   logic [1:0]  addrLo;
   logic [1:0]  sizeQ;
   logic        signQ;
   logic        writeQ;

   logic [3:0]  reqBe;
   logic [31:0] reqData;
   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic [31:0] loadData;

`ifdef MEM_ADDR_EXC_EN
   logic misaligned;
   assign misaligned = (memsize_i == 2'b01 && addr_i[0]) ||
                       (memsize_i[1] && addr_i[1:0] != 2'b00);
`endif

   // Stall is combinational in IDLE so the requesting instruction freezes immediately.
   always_comb begin
      unique case (state)
         IDLE:    stall_o = memen_i;
         BUSY:    stall_o = 1'b1;
         default: stall_o = 1'b0;
      endcase
   end

   // Byte enables and lane-replicated data for the request being issued.
   always_comb begin
      reqBe   = 4'b1111;
      reqData = wdata_i;
      if (memwrite_i) begin
         case (memsize_i)
            2'b00: begin
               reqBe   = 4'b0001 << addr_i[1:0];
               reqData = {4{wdata_i[7:0]}};
            end
            2'b01: begin
               reqBe   = addr_i[1] ? 4'b1100 : 4'b0011;
               reqData = {2{wdata_i[15:0]}};
            end
            default: begin
               reqBe   = 4'b1111;
               reqData = wdata_i;
            end
         endcase
      end
   end

   // Load lane extraction uses the captured address/size/sign, not the live inputs.
   always_comb begin
      byteSel = drdata_i[{addrLo, 3'b000} +: 8];
      halfSel = addrLo[1] ? drdata_i[31:16] : drdata_i[15:0];
      case (sizeQ)
         2'b00:   loadData = {{24{signQ & byteSel[7]}}, byteSel};
         2'b01:   loadData = {{16{signQ & halfSel[15]}}, halfSel};
         default: loadData = drdata_i;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         toCnt     <= '0;
         addrLo    <= '0;
         sizeQ     <= '0;
         signQ     <= 1'b0;
         writeQ    <= 1'b0;
         dreq_o    <= 1'b0;
         dwe_o     <= 1'b0;
         dbe_o     <= '0;
         daddr_o   <= '0;
         dwdata_o  <= '0;
         bus_err_o <= 1'b0;
         rdata_o   <= RESET_RDATA;
`ifdef MEM_ADDR_EXC_EN
         adel_o     <= 1'b0;
         ades_o     <= 1'b0;
         badvaddr_o <= '0;
`endif
      end else begin
         bus_err_o <= 1'b0;
`ifdef MEM_ADDR_EXC_EN
         adel_o <= 1'b0;
         ades_o <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (memen_i) begin
                  addrLo <= addr_i[1:0];
                  sizeQ  <= memsize_i;
                  signQ  <= memsign_i;
                  writeQ <= memwrite_i;
`ifdef MEM_ADDR_EXC_EN
                  if (misaligned) begin
                     adel_o     <= !memwrite_i;
                     ades_o     <= memwrite_i;
                     badvaddr_o <= addr_i;
                     state      <= DONE;
                  end else
`endif
                  begin
                     dreq_o   <= 1'b1;
                     dwe_o    <= memwrite_i;
                     dbe_o    <= reqBe;
                     daddr_o  <= {addr_i[31:2], 2'b00};
                     dwdata_o <= reqData;
                     toCnt    <= '0;
                     state    <= BUSY;
                  end
               end
            end
            BUSY: begin
               // An ack on the final watchdog cycle still completes normally.
               if (dack_i) begin
                  dreq_o <= 1'b0;
                  if (!writeQ) rdata_o <= loadData;
                  state <= DONE;
               end else if (toCnt == TO_LAST) begin
                  dreq_o    <= 1'b0;
                  rdata_o   <= RESET_RDATA;
                  bus_err_o <= 1'b1;
                  state     <= DONE;
               end else begin
                  toCnt <= toCnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
